// File: rtl/fbarb_pkg.sv
// Shared types and helpers for the frame-buffer arbiter.
//   fbarb_state_e    : arbiter FSM states (idle, write burst, read command)
//   fbarb_grant_e    : which master owned the most recent grant
//   fbarb_norm_burst : burstcount normalisation, 0 is treated as a single beat
package fbarb_pkg;

  localparam int unsigned MaxBurstW = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWrBurst = 2'd1,
    StRdCmd   = 2'd2
  } fbarb_state_e;

  typedef enum logic {
    GntWriter = 1'b0,
    GntReader = 1'b1
  } fbarb_grant_e;

  function automatic logic [MaxBurstW-1:0] fbarb_norm_burst(input logic [MaxBurstW-1:0] bc);
    return (bc == '0) ? MaxBurstW'(1) : bc;
  endfunction

endpackage

// File: rtl/fbarb_starve_timer.sv
// Writer starvation timer: saturating count of cycles the writer has waited.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   inc_i  : writer is requesting but does not hold the grant this cycle
//   clr_i  : writer is being granted this cycle (wins over inc_i)
//   hit_o  : count has reached Limit; writer must win the next arbitration
module fbarb_starve_timer #(
  parameter int unsigned Limit = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == CntW'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !hit_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller.
// Camera frame writer (write bursts) and video-out reader (read bursts) share one slave.
// Grants are burst-atomic; the reader wins while rd_urgent is high, otherwise round-robin.
//
// Optional build macro FBARB_STARVE_GUARD_EN: a writer starvation timer forces a
// write grant once the writer has waited STARVE_LIMIT cycles, overriding rd_urgent.
//
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   wr_*                          : writer slave port (address, write, writedata,
//                                   burstcount in; waitrequest out)
//   rd_*                          : reader slave port (address, read, burstcount,
//                                   urgent in; waitrequest, readdata, readdatavalid out)
//   m_*                           : master port to the SDRAM controller
module frame_buffer_arbiter
  import fbarb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned BURST_W      = 4,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  // writer
  input  logic [ADDR_W-1:0]  wr_address,
  input  logic               wr_write,
  input  logic [DATA_W-1:0]  wr_writedata,
  input  logic [BURST_W-1:0] wr_burstcount,
  output logic               wr_waitrequest,
  // reader
  input  logic [ADDR_W-1:0]  rd_address,
  input  logic               rd_read,
  input  logic [BURST_W-1:0] rd_burstcount,
  output logic               rd_waitrequest,
  output logic [DATA_W-1:0]  rd_readdata,
  output logic               rd_readdatavalid,
  input  logic               rd_urgent,
  // SDRAM controller
  output logic [ADDR_W-1:0]  m_address,
  output logic               m_read,
  output logic               m_write,
  output logic [DATA_W-1:0]  m_writedata,
  output logic [BURST_W-1:0] m_burstcount,
  input  logic               m_waitrequest,
  input  logic [DATA_W-1:0]  m_readdata,
  input  logic               m_readdatavalid
);

  fbarb_state_e       state_q, state_d;
  fbarb_grant_e       last_q, last_d;
  logic [BURST_W-1:0] beats_left_q, beats_left_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic grant_wr, grant_rd;
  logic starve_hit;

  // Read data returns independently of the command FSM, so writes may overlap it.
  assign rd_readdata      = m_readdata;
  assign rd_readdatavalid = m_readdatavalid;

`ifdef FBARB_STARVE_GUARD_EN
  fbarb_starve_timer #(
    .Limit (STARVE_LIMIT)
  ) u_starve_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .inc_i  (wr_write && (state_q != StWrBurst)),
    .clr_i  (grant_wr),
    .hit_o  (starve_hit)
  );
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign starve_hit          = 1'b0;
`endif

  // Arbitration, evaluated only in idle.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == StIdle) begin
      if (wr_write && (starve_hit || !rd_read)) begin
        grant_wr = 1'b1;
      end else if (rd_read && (!wr_write || rd_urgent)) begin
        grant_rd = 1'b1;
      end else if (wr_write && rd_read) begin
        // Tie: hand the slave to whoever did not have it last.
        if (last_q == GntWriter) begin
          grant_rd = 1'b1;
        end else begin
          grant_wr = 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    beats_left_d = beats_left_q;
    burst_d      = burst_q;
    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          last_d       = GntWriter;
          burst_d      = BURST_W'(fbarb_norm_burst(MaxBurstW'(wr_burstcount)));
          beats_left_d = BURST_W'(fbarb_norm_burst(MaxBurstW'(wr_burstcount)));
          state_d      = StWrBurst;
        end else if (grant_rd) begin
          last_d  = GntReader;
          state_d = StRdCmd;
        end
      end
      StWrBurst: begin
        // A writer gap just stalls; the grant is held until the last beat.
        if (wr_write && !m_waitrequest) begin
          beats_left_d = beats_left_q - BURST_W'(1);
          if (beats_left_q == BURST_W'(1)) begin
            state_d = StIdle;
          end
        end
      end
      StRdCmd: begin
        // Either the command was accepted or the reader withdrew it.
        if (!rd_read || !m_waitrequest) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_q       <= GntWriter;
      beats_left_q <= '0;
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      beats_left_q <= beats_left_d;
      burst_q      <= burst_d;
    end
  end

  // Command mux. Driven purely from the registered state so a reset drops the
  // command at once; waitrequest passes straight through to the owner.
  always_comb begin
    m_address      = '0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    m_writedata    = '0;
    m_burstcount   = '0;
    wr_waitrequest = 1'b1;
    rd_waitrequest = 1'b1;
    unique case (state_q)
      StWrBurst: begin
        m_address      = wr_address;
        m_write        = wr_write;
        m_writedata    = wr_writedata;
        m_burstcount   = burst_q;
        wr_waitrequest = m_waitrequest;
      end
      StRdCmd: begin
        m_address      = rd_address;
        m_read         = rd_read;
        m_burstcount   = rd_burstcount;
        rd_waitrequest = m_waitrequest;
      end
      default: ;
    endcase
  end

endmodule
